clk_pair_monitor: RTL and testbench

Checks the two quarter-phase slow clocks that the D5M clock divider produces. The block samples both slow clocks in the fast `ck` domain and measures each half-period plus the clk2-rise to clk1-rise offset. It compares these against expected values and reports lock plus sticky error status. It sits beside the divider as its consumer-side checker and feeds the status register bank and bring-up LEDs.

---
 rtl/clk_pair_monitor_if.sv | 22 ++
 rtl/clk_pair_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_clk_pair_monitor.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/clk_pair_monitor_if.sv
// Signal bundle between the slow-clock sources and the clock-pair monitor.
interface clk_pair_monitor_if;
    logic       clk1_in;
    logic       clk2_in;
    logic       err_clr;
    logic       locked;
    logic       period_err;
    logic       phase_err;
    logic [9:0] half_period;
    logic [9:0] phase;
    logic       meas_valid;

    modport master (
        output clk1_in, clk2_in, err_clr,
        input  locked, period_err, phase_err, half_period, phase, meas_valid
    );

    modport slave (
        input  clk1_in, clk2_in, err_clr,
        output locked, period_err, phase_err, half_period, phase, meas_valid
    );
endinterface

// File: rtl/clk_pair_monitor.sv
// Measures half-periods and clk2->clk1 rise offset of two quarter-phase slow
// clocks in the fast ck domain, tracks lock and keeps sticky error flags.
module clk_pair_monitor #(
    parameter int unsigned HALF_PERIOD = 252,
    parameter int unsigned PHASE       = 126,
    parameter int unsigned TOL         = 2,
    parameter int unsigned LOCK_N      = 4
) (
    input logic               ck,
    input logic               reset,
    clk_pair_monitor_if.slave bus
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [9:0]        HP_C   = 10'(HALF_PERIOD);
    localparam logic [9:0]        PH_C   = 10'(PHASE);
    localparam logic [9:0]        TO_C   = 10'(2 * HALF_PERIOD - 1);
    localparam logic signed [10:0] TOL_S = 11'(TOL);
    localparam logic [GW-1:0]     LAST_G = GW'(LOCK_N - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'd1023) ? v : v + 10'd1;
    endfunction

    function automatic logic is_good(input logic [9:0] m, input logic [9:0] expv);
        logic signed [10:0] diff;
        diff = $signed({1'b0, m}) - $signed({1'b0, expv});
        return (diff <= TOL_S) && (diff >= -TOL_S);
    endfunction

    // bit 0 = clk1, bit 1 = clk2 throughout the input pipeline
    logic [1:0] sync1_q, sync2_q, hist_q, edge_q, rise_q;

    logic [9:0] c1_q, c1_d, c2_q, c2_d, cp_q, cp_d;
    logic       arm1_q, arm1_d, arm2_q, arm2_d, seen2_q, seen2_d;
    state_t     state_q, state_d;
    logic [GW-1:0] g_q, g_d;

    logic       locked_q, locked_d, per_err_q, per_err_d, ph_err_q, ph_err_d;
    logic       mv_q, mv_d;
    logic [9:0] hp_q, hp_d, ph_q, ph_d;

    logic [9:0] m1_s, m2_s, pval_s;
    logic       meas1_s, meas2_s, pmeas_s, good1_s;
    logic       bad1_s, bad2_s, to1_s, to2_s, bad_ph_s, per_bad_s, any_bad_s;

    // Two-flop synchroniser, history flop and registered edge flags
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            hist_q  <= 2'b00;
            edge_q  <= 2'b00;
            rise_q  <= 2'b00;
        end else begin
            sync1_q <= {bus.clk2_in, bus.clk1_in};
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            edge_q  <= sync2_q ^ hist_q;
            rise_q  <= sync2_q & ~hist_q;
        end
    end

    // Counters, measurements and good/bad classification
    always_comb begin
        c1_d    = edge_q[0] ? 10'd0 : sat_inc(c1_q);
        c2_d    = edge_q[1] ? 10'd0 : sat_inc(c2_q);
        cp_d    = rise_q[1] ? 10'd0 : sat_inc(cp_q);
        arm1_d  = arm1_q | edge_q[0];
        arm2_d  = arm2_q | edge_q[1];
        seen2_d = seen2_q | rise_q[1];

        m1_s    = sat_inc(c1_q);
        m2_s    = sat_inc(c2_q);
        meas1_s = edge_q[0] & arm1_q;
        meas2_s = edge_q[1] & arm2_q;
        good1_s = meas1_s & is_good(m1_s, HP_C);
        bad1_s  = meas1_s & ~is_good(m1_s, HP_C);
        bad2_s  = meas2_s & ~is_good(m2_s, HP_C);
        // an edge on the stall-limit cycle is a measurement, not a timeout
        to1_s   = arm1_q & ~edge_q[0] & (c1_q == TO_C);
        to2_s   = arm2_q & ~edge_q[1] & (c2_q == TO_C);

        pmeas_s  = rise_q[0] & seen2_d;
        pval_s   = rise_q[1] ? 10'd0 : sat_inc(cp_q);
        bad_ph_s = pmeas_s & ~is_good(pval_s, PH_C);

        per_bad_s = bad1_s | bad2_s | to1_s | to2_s;
        any_bad_s = per_bad_s | bad_ph_s;
    end

    // FSM next state and good-measurement counter
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            ST_WAIT: begin
                g_d = {GW{1'b0}};
                if (arm1_d && arm2_d) begin
                    state_d = ST_ACQ;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACQ: begin
                if (any_bad_s) begin
                    g_d = {GW{1'b0}};
                end else if (good1_s) begin
                    if (g_q == LAST_G) begin
                        state_d = ST_LOCKED;
                        g_d     = {GW{1'b0}};
                    end else begin
                        g_d = g_q + GW'(1);
                    end
                end else begin
                    g_d = g_q;
                end
            end
            ST_LOCKED: begin
                if (any_bad_s) begin
                    state_d = ST_ACQ;
                    g_d     = {GW{1'b0}};
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_WAIT;
                g_d     = {GW{1'b0}};
            end
        endcase
    end

    // Output next values; a new error beats a same-cycle clear
    always_comb begin
        locked_d  = (state_d == ST_LOCKED);
        mv_d      = meas1_s;
        hp_d      = meas1_s ? m1_s : hp_q;
        ph_d      = pmeas_s ? pval_s : ph_q;
        if (per_bad_s) begin
            per_err_d = 1'b1;
        end else if (bus.err_clr) begin
            per_err_d = 1'b0;
        end else begin
            per_err_d = per_err_q;
        end
        if (bad_ph_s) begin
            ph_err_d = 1'b1;
        end else if (bus.err_clr) begin
            ph_err_d = 1'b0;
        end else begin
            ph_err_d = ph_err_q;
        end
    end

    // State, counter and output registers
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_WAIT;
            g_q       <= {GW{1'b0}};
            c1_q      <= 10'd0;
            c2_q      <= 10'd0;
            cp_q      <= 10'd0;
            arm1_q    <= 1'b0;
            arm2_q    <= 1'b0;
            seen2_q   <= 1'b0;
            locked_q  <= 1'b0;
            per_err_q <= 1'b0;
            ph_err_q  <= 1'b0;
            mv_q      <= 1'b0;
            hp_q      <= 10'd0;
            ph_q      <= 10'd0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            cp_q      <= cp_d;
            arm1_q    <= arm1_d;
            arm2_q    <= arm2_d;
            seen2_q   <= seen2_d;
            locked_q  <= locked_d;
            per_err_q <= per_err_d;
            ph_err_q  <= ph_err_d;
            mv_q      <= mv_d;
            hp_q      <= hp_d;
            ph_q      <= ph_d;
        end
    end

    assign bus.locked      = locked_q;
    assign bus.period_err  = per_err_q;
    assign bus.phase_err   = ph_err_q;
    assign bus.meas_valid  = mv_q;
    assign bus.half_period = hp_q;
    assign bus.phase       = ph_q;

endmodule

// File: tb/tb_clk_pair_monitor.sv
// Directed bench for clk_pair_monitor: a behavioural divider drives both slow
// clocks from the negedge of ck; outputs are sampled on the negedge.
module tb_clk_pair_monitor;

    logic ck = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // slow-clock generator state: cycles since toggle, current and pending half-periods
    int   cnt1, cnt2, hp1, hp2, str1, str2;
    bit   hold2;

    clk_pair_monitor_if bus();

    clk_pair_monitor dut (
        .ck    (ck),
        .reset (reset),
        .bus   (bus)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic gen_init(input int off2);
        bus.clk1_in = 1'b0;
        bus.clk2_in = 1'b0;
        cnt1 = 0;
        cnt2 = off2;
        hp1  = 252;
        hp2  = 252;
        str1 = 0;
        str2 = 0;
        hold2 = 1'b0;
    endtask

    task automatic tick();
        @(negedge ck);
        cnt1++;
        if (cnt1 >= hp1) begin
            bus.clk1_in = ~bus.clk1_in;
            cnt1 = 0;
            hp1  = (str1 > 0) ? str1 : 252;
            str1 = 0;
        end
        if (!hold2) begin
            cnt2++;
            if (cnt2 >= hp2) begin
                bus.clk2_in = ~bus.clk2_in;
                cnt2 = 0;
                hp2  = (str2 > 0) ? str2 : 252;
                str2 = 0;
            end
        end
    endtask

    function automatic logic lvl(input int sel);
        case (sel)
            0:       return bus.locked;
            1:       return bus.period_err;
            default: return bus.phase_err;
        endcase
    endfunction

    task automatic wait_lvl(input int sel, input int lim, input string tag);
        int n = 0;
        while (lvl(sel) !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 32'(lvl(sel)), 32'd1);
    endtask

    task automatic wait_mv(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.meas_valid !== 1'b1 && n < 700);
        chk(tag, 32'(bus.meas_valid), 32'd1);
    endtask

    task automatic do_reset(input int off2);
        @(negedge ck);
        reset = 1'b0;
        repeat (2) @(negedge ck);
        reset = 1'b1;
        gen_init(off2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " locked"},      32'(bus.locked),      32'd0);
        chk({tag, " period_err"},  32'(bus.period_err),  32'd0);
        chk({tag, " phase_err"},   32'(bus.phase_err),   32'd0);
        chk({tag, " meas_valid"},  32'(bus.meas_valid),  32'd0);
        chk({tag, " half_period"}, 32'(bus.half_period), 32'd0);
        chk({tag, " phase"},       32'(bus.phase),       32'd0);
    endtask

    initial begin
        logic prev_lk;
        int   n;
        int   early;

        reset       = 1'b0;
        bus.err_clr = 1'b0;
        gen_init(126);
        repeat (3) @(negedge ck);
        #1;
        chk_all_zero("reset");
        @(negedge ck);
        reset = 1'b1;
        gen_init(126);

        // 1: nominal clocks, lock on the 4th measurement
        for (int i = 1; i <= 4; i++) begin
            wait_mv("t1 meas_valid");
            chk("t1 half_period", 32'(bus.half_period), 32'd252);
            chk("t1 phase", 32'(bus.phase), 32'd126);
            chk("t1 locked", 32'(bus.locked), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("t1 period_err", 32'(bus.period_err), 32'd0);
        chk("t1 phase_err", 32'(bus.phase_err), 32'd0);

        // 2: both clocks stretched to 260 once (phase kept), then relock
        str1 = 260;
        str2 = 260;
        prev_lk = bus.locked;
        n = 0;
        while (bus.period_err !== 1'b1 && n < 600) begin
            prev_lk = bus.locked;
            tick();
            n++;
        end
        chk("t2 period_err", 32'(bus.period_err), 32'd1);
        chk("t2 locked before", 32'(prev_lk), 32'd1);
        chk("t2 locked drop", 32'(bus.locked), 32'd0);
        wait_mv("t2 meas_valid");
        chk("t2 stretched half_period", 32'(bus.half_period), 32'd260);
        for (int i = 1; i <= 4; i++) begin
            wait_mv("t2 relock meas_valid");
            chk("t2 half_period", 32'(bus.half_period), 32'd252);
            chk("t2 relock", 32'(bus.locked), (i == 4) ? 32'd1 : 32'd0);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("t2 cleared period_err", 32'(bus.period_err), 32'd0);
        chk("t2 cleared phase_err", 32'(bus.phase_err), 32'd0);

        // 3: clk2 stalls low after a falling edge
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.clk2_in == 1'b0 && cnt2 == 0) && n < 600);
        hold2 = 1'b1;
        repeat (507) tick();
        chk("t3 period_err before timeout", 32'(bus.period_err), 32'd0);
        tick();
        chk("t3 period_err timeout", 32'(bus.period_err), 32'd1);
        chk("t3 locked", 32'(bus.locked), 32'd0);
        chk("t3 phase", 32'(bus.phase), 32'd630);

        // 4: clk2 lags clk1 by 126, then is shifted back and errors cleared
        do_reset(-126);
        wait_lvl(2, 1200, "t4 phase_err");
        chk("t4 phase", 32'(bus.phase), 32'd378);
        chk("t4 locked", 32'(bus.locked), 32'd0);
        str2 = 504;
        repeat (1200) tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("t4 cleared phase_err", 32'(bus.phase_err), 32'd0);
        chk("t4 cleared period_err", 32'(bus.period_err), 32'd0);
        wait_lvl(0, 3000, "t4 relock");
        chk("t4 phase restored", 32'(bus.phase), 32'd126);
        chk("t4 no phase_err", 32'(bus.phase_err), 32'd0);

        // 5: clk2 delayed by 126 so both rise together
        str2 = 378;
        wait_lvl(2, 1200, "t5 phase_err");
        chk("t5 phase", 32'(bus.phase), 32'd0);
        chk("t5 locked", 32'(bus.locked), 32'd0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("t5 cleared phase_err", 32'(bus.phase_err), 32'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.clk1_in == 1'b1 && cnt1 == 0) && n < 700);
        repeat (3) tick();
        chk("t5 phase_err before collision", 32'(bus.phase_err), 32'd0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("t5 set beats clear", 32'(bus.phase_err), 32'd1);
        chk("t5 phase again", 32'(bus.phase), 32'd0);

        // 6: reset while locked, during a meas_valid pulse
        do_reset(126);
        wait_lvl(0, 2000, "t6 lock");
        wait_mv("t6 meas_valid");
        reset = 1'b0;
        #1;
        chk_all_zero("t6 reset");
        repeat (2) @(negedge ck);
        reset = 1'b1;
        gen_init(126);
        early = 0;
        for (int i = 1; i <= 507; i++) begin
            tick();
            if (bus.meas_valid === 1'b1) early++;
        end
        chk("t6 no meas on arming edge", 32'(early), 32'd0);
        chk("t6 not locked", 32'(bus.locked), 32'd0);
        tick();
        chk("t6 first meas_valid", 32'(bus.meas_valid), 32'd1);
        chk("t6 first half_period", 32'(bus.half_period), 32'd252);
        tick();
        chk("t6 meas_valid one cycle", 32'(bus.meas_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
